// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Widest operand the adder is intended to be built with.
  localparam int unsigned MaxWidth = 32;

  // Bit counter width; floor of one bit keeps WIDTH=2 legal.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the per-bit arithmetic core.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain combinational sum and majority carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock through a single full adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
// WIDTH is intended to lie in 2..MaxWidth.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, res_q, res_next, sum_q;
  logic              carry_q, cout_q;
  logic [CntW-1:0]   cnt_q;
  logic              last;
  logic              fa_sum, fa_cout;
  logic [WIDTH-1:0]  b_load;
  logic              c_load;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Operand conditioning at launch; subtract is a + ~b + 1.
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  // Terminal count, new sum bit entering at the MSB, and FSM next state.
  always_comb begin
    last     = (cnt_q == CntW'(WIDTH - 1));
    res_next = (res_q >> 1) | {fa_sum, {(WIDTH - 1){1'b0}}};
    state_d  = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, shift registers and result registers; reset abandons any add.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= c_load;
            cnt_q   <= '0;
            res_q   <= '0;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_cout;
          res_q   <= res_next;
          cnt_q   <= cnt_q + 1'b1;
          // Outputs only change here, so the old result holds through RUN.
          if (last) begin
            sum_q  <= res_next;
            cout_q <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  // Status decoded straight from the registered state.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=4.
// Subtract cases run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, cin8, sub8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] last8 = '0, hold8 = '0, pop8;
  logic [4:0] last4 = '0, hold4 = '0, pop4;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub8),
`endif
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding launch.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) check_eq("u8_spurious_done", 32'(done8), 32'd0);
      else begin
        pop8 = q8.pop_front();
        check_eq("u8_result", 32'({cout8, sum8}), 32'(pop8));
      end
    end
    if (done4 === 1'b1) begin
      if (q4.size() == 0) check_eq("u4_spurious_done", 32'(done4), 32'd0);
      else begin
        pop4 = q4.pop_front();
        check_eq("u4_result", 32'({cout4, sum4}), 32'(pop4));
      end
    end
  end

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    logic [8:0] e;
    e = s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b} + {8'd0, c});
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    q8.push_back(e);
    hold8 = last8;
    last8 = e;
    @(posedge clk);
    #1;
    // Operands change right after acceptance and must have no effect.
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~c; sub8 = ~s;
  endtask

  task automatic launch4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] e;
    e = {1'b0, a} + {1'b0, b} + {4'd0, c};
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    q4.push_back(e);
    hold4 = last4;
    last4 = e;
    @(posedge clk);
    #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = ~c;
  endtask

  // Waits for done; at cycle 'intrude' pulses start with a=100 to be ignored.
  task automatic wait8(input int intrude);
    int cyc = 0;
    int nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == intrude) begin start8 = 1'b1; a8 = 8'd100; end
      else start8 = 1'b0;
      if (busy8 === 1'b1) begin
        nbusy++;
        check_eq("u8_sum_held", 32'({cout8, sum8}), 32'(hold8));
      end
    end while (done8 !== 1'b1 && cyc < 40);
    start8 = 1'b0;
    check_eq("u8_latency", 32'(cyc), 32'd9);
    check_eq("u8_busy_cycles", 32'(nbusy), 32'd8);
    check_eq("u8_busy_in_done", 32'(busy8), 32'd0);
    @(negedge clk);
    check_eq("u8_done_one_cycle", 32'(done8), 32'd0);
  endtask

  task automatic wait4();
    int cyc = 0;
    int nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy4 === 1'b1) begin
        nbusy++;
        check_eq("u4_sum_held", 32'({cout4, sum4}), 32'(hold4));
      end
    end while (done4 !== 1'b1 && cyc < 40);
    check_eq("u4_latency", 32'(cyc), 32'd5);
    check_eq("u4_busy_cycles", 32'(nbusy), 32'd4);
    @(negedge clk);
    check_eq("u4_done_one_cycle", 32'(done4), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy8", 32'(busy8), 32'd0);
    check_eq("rst_done8", 32'(done8), 32'd0);
    check_eq("rst_result8", 32'({cout8, sum8}), 32'd0);
    check_eq("rst_busy4", 32'(busy4), 32'd0);
    check_eq("rst_result4", 32'({done4, cout4, sum4}), 32'd0);
    reset = 1'b0;

    launch8(8'd25, 8'd17, 1'b0, 1'b0);   wait8(0);
    launch8(8'hFF, 8'h01, 1'b0, 1'b0);   wait8(0);
    launch8(8'hFF, 8'h00, 1'b1, 1'b0);   wait8(0);

    // Start re-asserted mid-RUN must be dropped.
    launch8(8'd3, 8'd4, 1'b0, 1'b0);     wait8(3);
    repeat (4) @(negedge clk);

    // Reset during the 4th RUN cycle abandons the add.
    launch8(8'd50, 8'd60, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    void'(q8.pop_back());
    last8 = '0;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_busy8", 32'(busy8), 32'd0);
    check_eq("midrst_done8", 32'(done8), 32'd0);
    check_eq("midrst_result8", 32'({cout8, sum8}), 32'd0);
    repeat (12) @(negedge clk);
    launch8(8'd200, 8'd100, 1'b1, 1'b0); wait8(0);

    for (int i = 0; i < 6; i++) begin
      launch8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      wait8(0);
    end

    launch4(4'hA, 4'h7, 1'b0);           wait4();
    launch4(4'hF, 4'hF, 1'b1);           wait4();
    for (int i = 0; i < 4; i++) begin
      launch4(4'($urandom), 4'($urandom), 1'($urandom));
      wait4();
    end

`ifdef SERIAL_ADDER_SUB_EN
    launch8(8'h10, 8'h01, 1'b0, 1'b1);   wait8(0);
    launch8(8'h01, 8'h02, 1'b1, 1'b1);   wait8(0);
    launch8(8'h01, 8'h02, 1'b1, 1'b0);   wait8(0);
`endif

    repeat (4) @(negedge clk);
    check_eq("u8_queue_drained", 32'(q8.size()), 32'd0);
    check_eq("u4_queue_drained", 32'(q4.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
